// File: rtl/sw_seq_ctrl.sv
// Initiator side of the sw_req/sw_ack switch-timing handshake: stores a table of timing
// profiles and plays a programmed number of them to sw_driver, one request per profile.
module sw_seq_ctrl #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned GAP_CYC = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         reg_seq_en,
    input  logic [4:0]   reg_seq_steps,
    input  logic [31:0]  reg_timeout,
    input  logic         tbl_wr_en,
    input  logic [3:0]   tbl_wr_step,
    input  logic [4:0]   tbl_wr_ch,
    input  logic [13:0]  tbl_wr_data,
    input  logic         trig,
    output logic [335:0] sw_time_group,
    output logic         sw_req,
    input  logic         sw_ack,
    output logic         seq_busy,
    output logic         seq_done,
    output logic [3:0]   seq_step,
    output logic         err_timeout
);

    localparam int unsigned NCH = 24;
    localparam int unsigned TW  = 14;
    localparam int unsigned GW  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StGap,
        StReq,
        StDone
    } state_e;

    state_e         state_q, state_d;
    logic           trig_d;
    logic [4:0]     steps_q, steps_d;
    logic [31:0]    timeout_q, timeout_d;
    logic [31:0]    wdog_q, wdog_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic [3:0]     step_q, step_d;
    logic           req_q, req_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic [335:0]   group_q, group_d;

    logic [TW-1:0]  tbl_mem [DEPTH][NCH];
    logic [335:0]   load_group;
    logic           trig_edge;
    logic [4:0]     steps_clamped;
    logic           last_step;

    // Profile storage carries no reset; only entries that were written are ever meaningful.
    always_ff @(posedge clk) begin
        if (tbl_wr_en && (32'(tbl_wr_step) < DEPTH) && (tbl_wr_ch < 5'(NCH))) begin
            tbl_mem[tbl_wr_step][tbl_wr_ch] <= tbl_wr_data;
        end
    end

    always_comb begin
        load_group = '0;
        for (int c = 0; c < NCH; c++) begin
            load_group[c*TW +: TW] = tbl_mem[step_q][c];
        end
    end

    assign trig_edge     = trig & ~trig_d;
    assign steps_clamped = (32'(reg_seq_steps) > DEPTH) ? 5'(DEPTH) : reg_seq_steps;
    assign last_step     = (({1'b0, step_q} + 5'd1) == steps_q);

    always_comb begin
        state_d   = state_q;
        steps_d   = steps_q;
        timeout_d = timeout_q;
        wdog_d    = wdog_q;
        gap_d     = gap_q;
        step_d    = step_q;
        req_d     = req_q;
        err_d     = err_q;
        group_d   = group_q;

        unique case (state_q)
            StIdle: begin
                if (trig_edge && reg_seq_en) begin
                    steps_d   = steps_clamped;
                    timeout_d = reg_timeout;
                    step_d    = '0;
                    err_d     = 1'b0;
                    state_d   = (steps_clamped == 5'd0) ? StDone : StLoad;
                end
            end
            StLoad: begin
                group_d = load_group;
                gap_d   = '0;
                state_d = StGap;
            end
            StGap: begin
                req_d = 1'b0;
                if (gap_q == GW'(GAP_CYC - 1)) begin
                    req_d   = 1'b1;
                    wdog_d  = '0;
                    state_d = StReq;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            StReq: begin
                wdog_d = wdog_q + 32'd1;
                // An acknowledge in the timeout cycle still counts as success.
                if (sw_ack) begin
                    req_d = 1'b0;
                    if (last_step) begin
                        state_d = StDone;
                    end else begin
                        step_d  = step_q + 4'd1;
                        state_d = StLoad;
                    end
                end else if ((timeout_q != 32'd0) && (wdog_q == timeout_q - 32'd1)) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort: drop the request quietly, leaving step, error flag and profile as they were.
        if (!reg_seq_en && (state_q != StIdle)) begin
            state_d = StIdle;
            req_d   = 1'b0;
            err_d   = err_q;
            step_d  = step_q;
            group_d = group_q;
        end

        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            trig_d    <= 1'b0;
            steps_q   <= '0;
            timeout_q <= '0;
            wdog_q    <= '0;
            gap_q     <= '0;
            step_q    <= '0;
            req_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            group_q   <= '0;
        end else begin
            state_q   <= state_d;
            trig_d    <= trig;
            steps_q   <= steps_d;
            timeout_q <= timeout_d;
            wdog_q    <= wdog_d;
            gap_q     <= gap_d;
            step_q    <= step_d;
            req_q     <= req_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            group_q   <= group_d;
        end
    end

    assign sw_time_group = group_q;
    assign sw_req        = req_q;
    assign seq_busy      = busy_q;
    assign seq_done      = done_q;
    assign seq_step      = step_q;
    assign err_timeout   = err_q;

endmodule

// File: tb/tb_sw_seq_ctrl.sv
// Bench for sw_seq_ctrl: directed sequences checked every cycle against a timeline model,
// plus hand-computed expectations for latency, counts and reset behaviour.
module tb_sw_seq_ctrl;

    localparam int DEPTH = 16;
    localparam int GAP   = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         reg_seq_en = 1'b0;
    logic [4:0]   reg_seq_steps = '0;
    logic [31:0]  reg_timeout = '0;
    logic         tbl_wr_en = 1'b0;
    logic [3:0]   tbl_wr_step = '0;
    logic [4:0]   tbl_wr_ch = '0;
    logic [13:0]  tbl_wr_data = '0;
    logic         trig = 1'b0;
    logic [335:0] sw_time_group;
    logic         sw_req;
    logic         sw_ack = 1'b0;
    logic         seq_busy;
    logic         seq_done;
    logic [3:0]   seq_step;
    logic         err_timeout;

    sw_seq_ctrl #(.DEPTH(DEPTH), .GAP_CYC(GAP)) dut (
        .clk           (clk),
        .rst           (rst),
        .reg_seq_en    (reg_seq_en),
        .reg_seq_steps (reg_seq_steps),
        .reg_timeout   (reg_timeout),
        .tbl_wr_en     (tbl_wr_en),
        .tbl_wr_step   (tbl_wr_step),
        .tbl_wr_ch     (tbl_wr_ch),
        .tbl_wr_data   (tbl_wr_data),
        .trig          (trig),
        .sw_time_group (sw_time_group),
        .sw_req        (sw_req),
        .sw_ack        (sw_ack),
        .seq_busy      (seq_busy),
        .seq_done      (seq_done),
        .seq_step      (seq_step),
        .err_timeout   (err_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [335:0] act, input logic [335:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Timeline model: a step starts on an accepted trigger or an ack; the profile appears
    // one edge later and the request GAP+1 edges later.
    logic [13:0]  m_tbl [DEPTH][24];
    logic [335:0] m_group;
    logic         m_req, m_busy, m_done, m_err, m_trig_d;
    int           m_step, m_steps, m_cd, m_wait;
    logic [31:0]  m_to;

    task automatic model_reset();
        m_group = '0; m_req = 0; m_busy = 0; m_done = 0; m_err = 0; m_trig_d = 0;
        m_step = 0; m_steps = 0; m_cd = 0; m_wait = 0; m_to = '0;
    endtask

    initial begin
        for (int s = 0; s < DEPTH; s++)
            for (int c = 0; c < 24; c++) m_tbl[s][c] = '0;
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model_reset();
            end else begin
                logic edge_seen;
                edge_seen = trig && !m_trig_d;
                m_trig_d  = trig;
                if (!m_busy) begin
                    if (edge_seen && reg_seq_en) begin
                        m_steps = (int'(reg_seq_steps) > DEPTH) ? DEPTH : int'(reg_seq_steps);
                        m_to = reg_timeout; m_step = 0; m_err = 0; m_busy = 1;
                        if (m_steps == 0) m_done = 1;
                        else m_cd = GAP + 1;
                    end
                end else if (!reg_seq_en) begin
                    m_busy = 0; m_req = 0; m_done = 0;
                end else if (m_done) begin
                    m_done = 0; m_busy = 0;
                end else if (m_req) begin
                    m_wait++;
                    if (sw_ack) begin
                        m_req = 0;
                        if (m_step + 1 == m_steps) m_done = 1;
                        else begin m_step++; m_cd = GAP + 1; end
                    end else if (m_to != 0 && 32'(m_wait) == m_to) begin
                        m_req = 0; m_err = 1; m_done = 1;
                    end
                end else begin
                    m_cd--;
                    if (m_cd == GAP)
                        for (int c = 0; c < 24; c++) m_group[c*14 +: 14] = m_tbl[m_step][c];
                    if (m_cd == 0) begin m_req = 1; m_wait = 0; end
                end
                if (tbl_wr_en && tbl_wr_ch < 24) m_tbl[tbl_wr_step][tbl_wr_ch] = tbl_wr_data;
            end
        end
    end

    // Per-cycle compare plus event counters used by the directed checks.
    int   n_rise = 0, n_done = 0, n_hi = 0, grp_chg_hi = 0, low_run = 0;
    int   low_q[$];
    logic prev_req = 1'b0;
    logic [335:0] prev_grp = '0;

    always @(negedge clk) begin
        if (!rst) begin
            chk("sw_req", 32'(sw_req), 32'(m_req));
            chk("seq_busy", 32'(seq_busy), 32'(m_busy));
            chk("seq_done", 32'(seq_done), 32'(m_done));
            chk("seq_step", 32'(seq_step), 32'(m_step));
            chk("err_timeout", 32'(err_timeout), 32'(m_err));
            chk_w("sw_time_group", sw_time_group, m_group);
            if (sw_req && sw_time_group != prev_grp) grp_chg_hi++;
            if (sw_req && !prev_req) begin n_rise++; low_q.push_back(low_run); end
            if (sw_req) begin n_hi++; low_run = 0; end
            else low_run++;
            if (seq_done) n_done++;
        end
        prev_req = sw_req;
        prev_grp = sw_time_group;
    end

    task automatic wr(input int s, input int c, input int d);
        tbl_wr_en = 1; tbl_wr_step = 4'(s); tbl_wr_ch = 5'(c); tbl_wr_data = 14'(d);
        @(negedge clk);
        tbl_wr_en = 0;
    endtask

    task automatic pulse_trig();
        trig = 1;
        @(negedge clk);
        trig = 0;
    endtask

    task automatic pulse_ack();
        sw_ack = 1;
        @(negedge clk);
        sw_ack = 0;
    endtask

    task automatic wait_req(input int bound, output bit ok);
        ok = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (sw_req) begin ok = 1; break; end
        end
    endtask

    initial begin
        bit ok;
        int n, b_rise, b_done, b_hi, b_low;
        #2 rst = 1;
        #1;
        chk("rst sw_req", 32'(sw_req), 0);
        chk("rst busy", 32'(seq_busy), 0);
        chk_w("rst group", sw_time_group, '0);
        repeat (2) @(negedge clk);
        rst = 0;
        reg_seq_en = 1;
        for (int s = 0; s < DEPTH; s++)
            for (int c = 0; c < 24; c++) wr(s, c, s * 37 + c * 5 + 1);

        // 1: single step, latency and handshake timing
        wr(0, 0, 100);
        wr(0, 23, 5);
        reg_seq_steps = 1; reg_timeout = 0;
        trig = 1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            n++;
            if (n == 5) begin
                chk("t1 ch0", 32'(sw_time_group[13:0]), 100);
                chk("t1 ch23", 32'(sw_time_group[335:322]), 5);
            end
            if (sw_req) break;
        end
        chk("t1 latency", 32'(n), 6);
        @(negedge clk); trig = 0;
        repeat (8) @(negedge clk);
        sw_ack = 1;
        @(posedge clk); #1;
        chk("t1 req low", 32'(sw_req), 0);
        chk("t1 done", 32'(seq_done), 1);
        @(negedge clk); sw_ack = 0;
        @(posedge clk); #1;
        chk("t1 done gone", 32'(seq_done), 0);
        chk("t1 busy", 32'(seq_busy), 0);

        // 2: three steps, mid-sequence write to the active entry
        @(negedge clk);
        reg_seq_steps = 3;
        b_rise = n_rise; b_low = low_q.size();
        pulse_trig();
        for (int i = 0; i < 3; i++) begin
            wait_req(20, ok);
            chk("t2 req seen", 32'(ok), 1);
            chk("t2 step", 32'(seq_step), 32'(i));
            if (i == 1) wr(1, 0, 999);
            else @(negedge clk);
            repeat (6) @(negedge clk);
            pulse_ack();
        end
        repeat (4) @(negedge clk);
        chk("t2 requests", 32'(n_rise - b_rise), 3);
        for (int i = b_low + 1; i < low_q.size(); i++) chk("t2 low>=5", 32'(low_q[i] >= 5), 1);

        // 3: timeout after 20 request cycles, then cleared by next trigger
        reg_seq_steps = 1; reg_timeout = 20;
        b_hi = n_hi; b_done = n_done;
        pulse_trig();
        repeat (40) @(negedge clk);
        chk("t3 req cycles", 32'(n_hi - b_hi), 20);
        chk("t3 err", 32'(err_timeout), 1);
        chk("t3 dones", 32'(n_done - b_done), 1);
        reg_timeout = 0;
        pulse_trig();
        @(negedge clk);
        chk("t3 err cleared", 32'(err_timeout), 0);
        wait_req(20, ok);
        pulse_ack();
        repeat (3) @(negedge clk);

        // 4: enable dropped during a request
        b_done = n_done;
        pulse_trig();
        wait_req(20, ok);
        repeat (2) @(negedge clk);
        reg_seq_en = 0;
        @(negedge clk);
        chk("t4 req", 32'(sw_req), 0);
        chk("t4 busy", 32'(seq_busy), 0);
        reg_seq_en = 1;
        repeat (3) @(negedge clk);
        chk("t4 no done", 32'(n_done - b_done), 0);

        // 5: zero steps, then clamped 31 steps with an ignored retrigger
        reg_seq_steps = 0;
        b_rise = n_rise; b_done = n_done;
        pulse_trig();
        repeat (10) @(negedge clk);
        chk("t5 zero done", 32'(n_done - b_done), 1);
        chk("t5 zero req", 32'(n_rise - b_rise), 0);
        reg_seq_steps = 31;
        b_rise = n_rise; b_done = n_done;
        pulse_trig();
        for (int i = 0; i < 16; i++) begin
            wait_req(20, ok);
            chk("t5 req seen", 32'(ok), 1);
            if (i == 0) pulse_trig();
            @(negedge clk);
            pulse_ack();
        end
        repeat (30) @(negedge clk);
        chk("t5 requests", 32'(n_rise - b_rise), 16);
        chk("t5 dones", 32'(n_done - b_done), 1);

        // 6: reset during a request coinciding with an ack
        reg_seq_steps = 2;
        b_done = n_done;
        pulse_trig();
        wait_req(20, ok);
        @(negedge clk);
        sw_ack = 1; rst = 1;
        #1;
        chk("t6 req", 32'(sw_req), 0);
        chk("t6 busy", 32'(seq_busy), 0);
        chk("t6 step", 32'(seq_step), 0);
        chk_w("t6 group", sw_time_group, '0);
        @(negedge clk); sw_ack = 0;
        @(negedge clk); rst = 0;
        repeat (5) @(negedge clk);
        chk("t6 no done", 32'(n_done - b_done), 0);
        chk("group stable in req", 32'(grp_chg_hi), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
